mmio_bridge: RTL

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_pkg.sv | 48 ++++
 rtl/mmio_load_align.sv | 28 ++
 rtl/mmio_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: FSM states, access classes,
// IO window offsets, RISC-V load/store funct3 codes and store lane helpers.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    IO_WAIT,
    RESP
  } bridgeStateT;

  typedef enum logic [2:0] {
    ACC_MEM_LD,
    ACC_MEM_ST,
    ACC_IO_RD,
    ACC_IO_WR,
    ACC_BTN,
    ACC_ERR
  } accessKindT;

  localparam logic [31:0] RD_OFFSET  = 32'h0000_0000;
  localparam logic [31:0] WR_OFFSET  = 32'h0000_0100;
  localparam logic [31:0] BTN_OFFSET = 32'h0000_0200;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic [3:0] storeMask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] storeLanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mmio_load_align.sv
// Selects the addressed byte/half lane of a loaded word and sign- or
// zero-extends it according to the RISC-V load funct3.
module mmio_load_align
  import mmio_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'b0, shifted[7:0]};
      F3_HU:   data = {16'b0, shifted[15:0]};
      F3_W:    data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU load/store bridge splitting accesses between data memory and an IO window.
// Define MMIO_TIMEOUT_EN to abort IO reads that are never acknowledged.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int N_RD    = 4,
  parameter int N_WR    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                req_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                mem_en,
  output logic [3:0]          mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic [N_RD-1:0]     io_rd_sel,
  input  logic [N_RD-1:0]     io_rd_ack,
  input  logic [32*N_RD-1:0]  io_rd_data,
  output logic [32*N_WR-1:0]  io_wr_q,
  output logic [N_WR-1:0]     io_wr_stb,
  input  logic                btn_in
);

  bridgeStateT       state, stateNext;
  accessKindT        kind;
  logic              accept, memMis, sizeBad, ackSel, timedOut;
  logic              sticky, btnPrev, btnEdge, errQ;
  logic [31:0]       ioOff, rdOff, wrOff, rdataQ, loadData, chData;
  logic [3:0]        rdCh, wrCh, chQ;
  logic [1:0]        offQ;
  logic [2:0]        funct3Q;
  logic [N_WR-1:0]   wrStbQ;
  logic [32*N_WR-1:0] wrQ;
  logic [15:0]       waitCnt;

  assign ioOff   = req_addr - IO_BASE;
  assign rdOff   = ioOff - RD_OFFSET;
  assign wrOff   = ioOff - WR_OFFSET;
  assign rdCh    = rdOff[5:2];
  assign wrCh    = wrOff[5:2];
  assign accept  = (state == IDLE) && req_valid;
  assign btnEdge = btn_in & ~btnPrev;

  assign memMis  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign sizeBad = (req_funct3[1:0] == 2'b11) ||
                   (req_funct3[2] && (req_write || req_funct3[1]));

  // IO reads/writes must hit an exact word of an existing channel; the button is read-only
  always_comb begin
    kind = ACC_ERR;
    if (req_addr >= IO_BASE) begin
      if (!req_write && rdOff < 32'(4 * N_RD) && rdOff[1:0] == 2'b00)
        kind = ACC_IO_RD;
      else if (req_write && wrOff < 32'(4 * N_WR) && wrOff[1:0] == 2'b00)
        kind = ACC_IO_WR;
      else if (!req_write && ioOff == BTN_OFFSET)
        kind = ACC_BTN;
    end else if (!sizeBad && !memMis) begin
      kind = req_write ? ACC_MEM_ST : ACC_MEM_LD;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    if (accept && (kind == ACC_MEM_LD || kind == ACC_MEM_ST)) begin
      mem_en   = 1'b1;
      mem_addr = {req_addr[31:2], 2'b00};
      if (kind == ACC_MEM_ST) begin
        mem_we    = storeMask(req_funct3[1:0], req_addr[1:0]);
        mem_wdata = storeLanes(req_funct3[1:0], req_wdata);
      end
    end
  end

  always_comb begin
    chData    = 32'b0;
    ackSel    = 1'b0;
    io_rd_sel = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (chQ == 4'(k)) begin
        chData       = io_rd_data[32*k +: 32];
        ackSel       = io_rd_ack[k];
        io_rd_sel[k] = (state == IO_WAIT);
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  assign timedOut = (state == IO_WAIT) && !ackSel && (waitCnt == 16'(TIMEOUT - 1));
`else
  assign timedOut = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (kind == ACC_IO_RD)       stateNext = IO_WAIT;
          else if (kind == ACC_MEM_LD) stateNext = MEM_WAIT;
          else                         stateNext = RESP;
        end
      end
      MEM_WAIT: stateNext = RESP;
      IO_WAIT:  if (ackSel || timedOut) stateNext = RESP;
      RESP:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  mmio_load_align loadAlign (
    .word   (mem_rdata),
    .offset (offQ),
    .funct3 (funct3Q),
    .data   (loadData)
  );

  // A button edge coinciding with a button read keeps the sticky bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      offQ    <= 2'b00;
      funct3Q <= 3'b000;
      chQ     <= 4'b0;
      rdataQ  <= 32'b0;
      errQ    <= 1'b0;
      wrStbQ  <= '0;
      wrQ     <= '0;
      sticky  <= 1'b0;
      btnPrev <= 1'b0;
      waitCnt <= 16'b0;
    end else begin
      state   <= stateNext;
      btnPrev <= btn_in;
      wrStbQ  <= '0;
      if (btnEdge)
        sticky <= 1'b1;
      else if (accept && kind == ACC_BTN)
        sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            offQ    <= req_addr[1:0];
            funct3Q <= req_funct3;
            chQ     <= rdCh;
            waitCnt <= 16'b0;
            rdataQ  <= (kind == ACC_BTN) ? {31'b0, sticky} : 32'b0;
            errQ    <= (kind == ACC_ERR);
            for (int j = 0; j < N_WR; j++) begin
              if (kind == ACC_IO_WR && wrCh == 4'(j)) begin
                wrQ[32*j +: 32] <= req_wdata;
                wrStbQ[j]       <= 1'b1;
              end
            end
          end
        end
        MEM_WAIT: rdataQ <= loadData;
        IO_WAIT: begin
          if (ackSel) begin
            rdataQ <= chData;
          end else begin
            if (waitCnt != 16'(TIMEOUT)) waitCnt <= waitCnt + 16'd1;
            if (timedOut) errQ <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == RESP);
  assign rsp_rdata = req_ready ? rdataQ : 32'b0;
  assign rsp_err   = req_ready & errQ;
  assign io_wr_q   = wrQ;
  assign io_wr_stb = wrStbQ;

endmodule
